// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the sequential 8x8 multiplier controller: FSM encoding,
// step count and the per-step nibble/shift schedule.
package mult_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int STEPS = 4;
  localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

  typedef struct packed {
    logic       a_hi;
    logic       b_hi;
    logic [3:0] shift;
  } step_cfg_t;

  // Nibble selection and left shift of the partial product for each step.
  function automatic step_cfg_t step_cfg(input logic [1:0] step);
    step_cfg_t c;
    case (step)
      2'd0:    c = '{a_hi: 1'b0, b_hi: 1'b0, shift: 4'd0};
      2'd1:    c = '{a_hi: 1'b0, b_hi: 1'b1, shift: 4'd4};
      2'd2:    c = '{a_hi: 1'b1, b_hi: 1'b0, shift: 4'd4};
      default: c = '{a_hi: 1'b1, b_hi: 1'b1, shift: 4'd8};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/R2_4x4_mul.sv
// Approximate 4x4 multiplier: exact product with the two least significant
// result bits truncated to zero.
module R2_4x4_mul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [7:0] exact;

  assign exact = {4'b0000, a} * {4'b0000, b};
  assign p     = {exact[7:2], 2'b00};

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 multiplier: one approximate 4x4 multiplier time-shared over four
// CALC cycles, with optional zero-operand bypass.
module mult_8x8_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic        mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R,
  output logic        busy,
  output state_e      state_dbg
);

  // Handshake: an operand pair transfers on a rising edge where in_valid and
  // in_ready are both 1; a result transfers where out_valid and out_ready are
  // both 1. out_valid and R hold steady until that result transfer.

  state_e      state;
  logic [1:0]  step;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic        mode_q;
  logic [15:0] acc;

  step_cfg_t   cfg;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_sh;
  logic [15:0] acc_next;

  always_comb begin
    cfg      = step_cfg(step);
    nib_a    = cfg.a_hi ? a_q[7:4] : a_q[3:0];
    nib_b    = cfg.b_hi ? b_q[7:4] : b_q[3:0];
    pp_sh    = {8'h00, pp} << cfg.shift;
    acc_next = mode_q ? (acc | pp_sh) : (acc + pp_sh);
  end

  R2_4x4_mul u_mul (
    .a (nib_a),
    .b (nib_b),
    .p (pp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= 2'd0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      mode_q    <= 1'b0;
      acc       <= 16'h0000;
      R         <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= A;
            b_q    <= B;
            mode_q <= mode;
            acc    <= 16'h0000;
            step   <= 2'd0;
            if (ZERO_BYPASS && (A == 8'h00 || B == 8'h00)) begin
              R         <= 16'h0000;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          if (step == LAST_STEP) begin
            R         <= acc_next;
            out_valid <= 1'b1;
            step      <= 2'd0;
            state     <= DONE;
          end else begin
            step <= step + 2'd1;
          end
        end
        DONE: begin
          // Returning to IDLE (not straight into a new transfer) costs one cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Directed scoreboard bench for mult_8x8_seq_ctrl: driver pushes expected results,
// a negedge monitor pops and compares whenever out_valid rises.
module tb_mult_8x8_seq_ctrl;
  import mult_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid = 1'b0;
  logic        in_valid_nb = 1'b0;
  logic        out_ready = 1'b1;
  logic        mode = 1'b0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;

  logic        in_ready, out_valid, busy;
  logic [15:0] r;
  state_e      dbg;
  logic        in_ready_nb, out_valid_nb, busy_nb;
  logic [15:0] r_nb;
  state_e      dbg_nb;

  mult_8x8_seq_ctrl #(.ZERO_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .R(r), .busy(busy), .state_dbg(dbg)
  );

  mult_8x8_seq_ctrl #(.ZERO_BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_nb), .in_ready(in_ready_nb),
    .A(a), .B(b), .mode(mode), .out_valid(out_valid_nb), .out_ready(out_ready),
    .R(r_nb), .busy(busy_nb), .state_dbg(dbg_nb)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int          lat_q[$];
  int          tx_q[$];
  int          errors = 0;
  int          checks = 0;
  int          n_out = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  logic        prev_ov = 1'b0;
  logic        chk_ir = 1'b0;
  logic [15:0] held_r = 16'h0;
  logic [15:0] e_r;
  int          e_l, t_c;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
      chk_ir  = 1'b0;
    end else begin
      if (chk_ir) check("in_ready_drop", {31'b0, in_ready}, 32'd0);
      chk_ir = 1'b0;
      if (in_valid && in_ready) begin
        tx_q.push_back(cyc + 1);
        chk_ir = 1'b1;
      end
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0 || tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got R=%0h, expected no result (t=%0t)", r, $time);
        end else begin
          e_r = exp_q.pop_front();
          e_l = lat_q.pop_front();
          t_c = tx_q.pop_front();
          check("result_R", {16'b0, r}, {16'b0, e_r});
          check("latency", 32'(cyc - t_c), 32'(e_l));
          check("busy_done", {31'b0, busy}, 32'd1);
        end
        n_out++;
      end else if (out_valid) begin
        check("R_stable", {16'b0, r}, {16'b0, held_r});
        check("in_ready_hold", {31'b0, in_ready}, 32'd0);
      end
      prev_ov = out_valid;
      held_r  = r;
    end
  end

  // ---------------- driver tasks ----------------
  // Latency is counted in edges from the transfer edge to the edge after which
  // out_valid is first high: 4 through CALC, 0 when bypassed (DONE on the transfer edge).
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic mv,
                      input logic [15:0] er, input int el, input bit scramble);
    int k = 0;
    @(posedge clk) #1;
    a = av; b = bv; mode = mv; in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      @(posedge clk) #1;
      k++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(er);
    lat_q.push_back(el);
    @(posedge clk) #1;
    in_valid = 1'b0;
    if (scramble) begin
      for (int i = 0; i < 3; i++) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        mode = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
        @(posedge clk) #1;
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input int target);
    int k = 0;
    while (n_out < target && k < 60) begin
      @(posedge clk) #1;
      k++;
    end
    if (n_out < target) begin
      checks++;
      errors++;
      $display("FAIL wait_out: got %0d results, expected %0d", n_out, target);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int n_before;
    #12;
    check("rst_R", {16'b0, r}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_state", {30'b0, dbg}, {30'b0, IDLE});
    @(negedge clk) rst_n = 1'b1;
    #1 check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 23x45 add: 0x0C + 0x0C<<4 + 0x08<<4 + 0x08<<8
    send(8'h23, 8'h45, 1'b0, 16'h094C, 4, 1'b0);
    wait_out(1);
    // Same operands, OR fold: 0x0C | 0xC0 | 0x80 | 0x800
    send(8'h23, 8'h45, 1'b1, 16'h08CC, 4, 1'b0);
    wait_out(2);
    send(8'h00, 8'hFF, 1'b0, 16'h0000, 0, 1'b0);
    wait_out(3);
    send(8'h5A, 8'h00, 1'b1, 16'h0000, 0, 1'b0);
    wait_out(4);

    // Zero operand without bypass goes through all four CALC steps.
    @(posedge clk) #1;
    a = 8'h00; b = 8'hFF; mode = 1'b0; in_valid_nb = 1'b1;
    check("nb_in_ready", {31'b0, in_ready_nb}, 32'd1);
    @(posedge clk) #1;
    in_valid_nb = 1'b0;
    k = 0;
    while (!out_valid_nb && k < 20) begin
      @(posedge clk) #1;
      k++;
    end
    check("nb_latency", 32'(k), 32'd4);
    check("nb_R", {16'b0, r_nb}, 32'd0);

    // FFxFF add: 0xE0 + 0xE00 + 0xE00 + 0xE000, consumer stalled 10 cycles.
    out_ready = 1'b0;
    send(8'hFF, 8'hFF, 1'b0, 16'hFCE0, 4, 1'b0);
    wait_out(5);
    repeat (10) @(posedge clk) #1;
    check("stall_out_valid", {31'b0, out_valid}, 32'd1);
    check("stall_R", {16'b0, r}, 32'h0000FCE0);
    out_ready = 1'b1;
    @(posedge clk) #1;
    out_ready = 1'b1;
    check("release_state", {30'b0, dbg}, {30'b0, IDLE});
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    check("release_out_valid", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of CALC (step 2) drops the operation.
    send(8'h9C, 8'h7E, 1'b0, 16'h0000, 4, 1'b0);
    @(posedge clk) #1;
    @(posedge clk) #2;
    n_before = n_out;
    rst_n = 1'b0;
    #1;
    check("midrst_R", {16'b0, r}, 32'd0);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_state", {30'b0, dbg}, {30'b0, IDLE});
    exp_q.delete();
    lat_q.delete();
    tx_q.delete();
    @(negedge clk) rst_n = 1'b1;
    #1 check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (8) @(posedge clk) #1;
    check("midrst_no_output", 32'(n_out), 32'(n_before));

    // 10x01: only step 2 is nonzero, R2(1,1)=0.
    send(8'h10, 8'h01, 1'b0, 16'h0000, 4, 1'b0);
    wait_out(n_before + 1);
    // 57xB6 add with inputs churned during CALC: 0x28 + 0x4C0 + 0x1C0 + 0x3400
    send(8'h57, 8'hB6, 1'b0, 16'h3AA8, 4, 1'b1);
    wait_out(n_before + 2);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
